lsu_mem_ctrl: RTL and testbench

Load/store initiator that drives the byte-masked, word-indexed data memory port (addr, wdata, 4-bit byte mask, write enable, combinational read data) on behalf of the core.
- Accepts one byte-addressed load or store request at a time using RISC-V funct3 encodings.
- Stores: generates the word index, lane-shifted write data and byte mask.
- Loads: aligns the returned word and sign- or zero-extends the result.
- Sits between the execute stage and the data memory.

---
 rtl/lsu_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a byte-masked, word-indexed data memory with combinational read data.
// Define MISALIGN_SPLIT_EN to complete word-crossing accesses as two word accesses; otherwise they return an error.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic legal_f(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] size_f(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            2'b10:   n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] size_mask_f(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Lane-align a (possibly two-word) load and extend it to 32 bits.
    function automatic logic [31:0] load_extend_f(input logic [63:0] dw, input logic [1:0] off,
                                                  input logic [2:0] f3);
        logic [31:0] sh;
        logic [31:0] r;
        sh = 32'(dw >> {off, 3'b000});
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = sh;
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] lo_word_q, lo_word_d;
`ifdef MISALIGN_SPLIT_EN
    logic        cross_q, cross_d;
    logic [31:0] hi_word_q, hi_word_d;
`endif

    logic              cross_in_s;
    logic              illegal_in_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [63:0]       load_dw_s;
    logic [3:0]        bmask_lo_s;

    assign cross_in_s   = ({1'b0, i_req_addr[1:0]} + size_f(i_req_funct3[1:0])) > 3'd4;
    assign illegal_in_s = ~legal_f(i_req_we, i_req_funct3);
    assign word_idx_s   = ADDR_W'(addr_q >> 2);

`ifdef MISALIGN_SPLIT_EN
    logic [7:0] bmask_wide_s;
    logic [3:0] bmask_hi_s;
    assign bmask_wide_s = {4'b0000, size_mask_f(f3_q[1:0])} << addr_q[1:0];
    assign bmask_lo_s   = bmask_wide_s[3:0];
    assign bmask_hi_s   = bmask_wide_s[7:4];
    assign load_dw_s    = {hi_word_q, lo_word_q};
`else
    assign bmask_lo_s   = size_mask_f(f3_q[1:0]) << addr_q[1:0];
    assign load_dw_s    = {32'h0000_0000, lo_word_q};
`endif

    // Next-state and request/capture register update.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        lo_word_d = lo_word_q;
`ifdef MISALIGN_SPLIT_EN
        cross_d   = cross_q;
        hi_word_d = hi_word_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    f3_d    = i_req_funct3;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
`ifdef MISALIGN_SPLIT_EN
                    cross_d = cross_in_s;
                    err_d   = illegal_in_s;
`else
                    err_d   = illegal_in_s | cross_in_s;
`endif
                    state_d = ACC0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC0: begin
                lo_word_d = i_mem_rdata;
`ifdef MISALIGN_SPLIT_EN
                if (cross_q && !err_q) begin
                    state_d = ACC1;
                end else begin
                    state_d = RESP;
                end
`else
                state_d = RESP;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            ACC1: begin
                hi_word_d = i_mem_rdata;
                state_d   = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state and latched request.
    always_comb begin
        o_req_ready = (state_q == IDLE);
        o_rsp_valid = 1'b0;
        o_rsp_rdata = 32'h0000_0000;
        o_rsp_err   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = 32'h0000_0000;
        o_mem_bmask = 4'b0000;
        o_mem_wren  = 1'b0;
        case (state_q)
            ACC0: begin
                o_mem_addr = word_idx_s;
                if (we_q && !err_q) begin
                    o_mem_wren  = 1'b1;
                    o_mem_bmask = bmask_lo_s;
                    o_mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
                end else begin
                    o_mem_wren  = 1'b0;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ACC1: begin
                o_mem_addr = word_idx_s + ADDR_W'(1);
                if (we_q && !err_q) begin
                    o_mem_wren  = 1'b1;
                    o_mem_bmask = bmask_hi_s;
                    // ACC1 is only reached with off in 1..3, so the shift stays below 32.
                    o_mem_wdata = wdata_q >> {(3'd4 - {1'b0, addr_q[1:0]}), 3'b000};
                end else begin
                    o_mem_wren  = 1'b0;
                end
            end
`endif
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = err_q;
                if (!we_q && !err_q) begin
                    o_rsp_rdata = load_extend_f(load_dw_s, addr_q[1:0], f3_q);
                end else begin
                    o_rsp_rdata = 32'h0000_0000;
                end
            end
            default: o_req_ready = (state_q == IDLE);
        endcase
    end

    // State and request registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
            lo_word_q <= 32'h0000_0000;
`ifdef MISALIGN_SPLIT_EN
            cross_q   <= 1'b0;
            hi_word_q <= 32'h0000_0000;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            lo_word_q <= lo_word_d;
`ifdef MISALIGN_SPLIT_EN
            cross_q   <= cross_d;
            hi_word_q <= hi_word_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized scoreboard bench for lsu_mem_ctrl against a byte-level memory reference model.
module tb_lsu_mem_ctrl;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_bmask;
    logic        mem_wren;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
        .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
    );

    // 64-word environment memory; low address bits alias.
    logic [31:0] tb_mem [64];
    logic        mem_init = 1'b1;
    assign mem_rdata = tb_mem[mem_addr[5:0]];

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'hA5C3_0F17;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 64; w++) tb_mem[w] <= init_word(w);
        end else if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_bmask[b]) tb_mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int miscmp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory and access rules.
    logic [7:0] ref_mem [256];

    function automatic int fsize(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit flegal(input logic we, input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
        if (f3 == 3'b100 || f3 == 3'b101) return !we;
        return 1'b0;
    endfunction

    function automatic bit fcross(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) + fsize(f3)) > 4;
    endfunction

    function automatic bit ferr(input logic we, input logic [2:0] f3, input logic [31:0] a);
        return !flegal(we, f3) || (fcross(f3, a) && !SPLIT);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    logic        cur_we;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wd;
    int          cur_t = -100;

    // Scoreboard monitor: every response strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                vec_cnt++;
                miscmp++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 with rdata %h expected no response", rsp_rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Memory-port monitor: which bytes the current store must write, and when.
    always @(negedge clk) begin
        int          beat;
        logic        exp_wren;
        logic [31:0] wi, ba, k, lane_m, ewd;
        logic [3:0]  emask;
        beat     = cyc - cur_t;
        exp_wren = 1'b0;
        wi       = 32'h0;
        if (cur_we && !ferr(cur_we, cur_f3, cur_addr)) begin
            if (beat == 1) begin
                exp_wren = 1'b1;
                wi = cur_addr >> 2;
            end else if (beat == 2 && SPLIT && fcross(cur_f3, cur_addr)) begin
                exp_wren = 1'b1;
                wi = (cur_addr >> 2) + 32'd1;
            end
        end
        check("mem_wren", 32'(mem_wren), 32'(exp_wren));
        if (exp_wren && mem_wren) begin
            emask  = 4'b0000;
            lane_m = 32'h0;
            ewd    = 32'h0;
            for (int b = 0; b < 4; b++) begin
                ba = wi * 32'd4 + 32'(b);
                k  = ba - cur_addr;
                if (k < 32'(fsize(cur_f3))) begin
                    emask[b]          = 1'b1;
                    lane_m[b*8 +: 8]  = 8'hFF;
                    ewd[b*8 +: 8]     = cur_wd[k[1:0]*8 +: 8];
                end
            end
            check("mem_addr", mem_addr, wi);
            check("mem_bmask", 32'(mem_bmask), 32'(emask));
            check("mem_wdata", mem_wdata & lane_m, ewd);
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 32'(req_ready), 32'd1);
        cur_we    = we;
        cur_f3    = f3;
        cur_addr  = a;
        cur_wd    = wd;
        cur_t     = cyc;
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom();
        req_addr  = $urandom();
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gap);
        exp_t        e;
        logic [31:0] v;
        bit          err;
        int          sz;
        issue(we, f3, a, wd, gap);
        err = ferr(we, f3, a);
        sz  = fsize(f3);
        v   = 32'h0;
        if (!err && we) begin
            for (int i = 0; i < sz; i++) ref_mem[8'(a + 32'(i))] = wd[i*8 +: 8];
        end else if (!err) begin
            for (int i = 0; i < sz; i++) v[i*8 +: 8] = ref_mem[8'(a + 32'(i))];
            if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end
        e.rdata = v;
        e.err   = err;
        e.due   = cur_t + ((!err && fcross(f3, a) && SPLIT) ? 3 : 2);
        sb_q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] legal_f3 [5];
        logic [31:0] ra;
        int n;
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
        for (int w = 0; w < 64; w++)
            for (int b = 0; b < 4; b++) begin
                ra = init_word(w);
                ref_mem[w*4 + b] = ra[b*8 +: 8];
            end

        i_reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_bmask", 32'(mem_bmask), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        i_reset  = 1'b0;
        mem_init = 1'b0;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_1234, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        do_req(1'b1, 3'b010, 32'h0E, 32'hAABB_CCDD, 0);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, 0);
        do_req(1'b0, 3'b011, 32'h20, 32'h0, 0);
        do_req(1'b1, 3'b100, 32'h24, 32'h55, 0);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_9876, 0);
        do_req(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, 0);

        // Reset in the middle of a store: no response, no late write.
        issue(1'b1, 3'b010, SPLIT ? 32'h2E : 32'h20, 32'h1122_3344, 0);
        if (SPLIT) @(posedge clk);
        #2;
        cur_t   = -100;
        i_reset = 1'b1;
        #1;
        check("midrst_wren", 32'(mem_wren), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        if (SPLIT) begin
            for (int i = 0; i < 4; i++)
                if (((32'h2E + 32'(i)) >> 2) == (32'h2E >> 2))
                    ref_mem[8'(32'h2E + 32'(i))] = cur_wd[i*8 +: 8];
        end
        @(negedge clk);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            int r;
            r = $urandom_range(0, 15);
            if (r < 13)       f3 = legal_f3[r % 5];
            else if (r == 13) f3 = 3'b011;
            else if (r == 14) f3 = 3'b110;
            else              f3 = 3'b111;
            do_req(1'($urandom_range(0, 1)), f3, $urandom(), $urandom(), $urandom_range(0, 2));
        end

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        for (int w = 0; w < 64; w++)
            check("mem_word", tb_mem[w],
                  {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
